// File: rtl/joy_pkg.sv
// Shared types and constants for the dual-pad joystick scan scheduler.
// Button indices follow the serial shift order: B is shifted in first and lands at bit 0.
package joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HIGH,
    ST_CLK_LOW,
    ST_PUBLISH
  } joy_state_t;

  typedef enum logic [3:0] {
    BTN_B      = 4'd0,
    BTN_Y      = 4'd1,
    BTN_SELECT = 4'd2,
    BTN_START  = 4'd3,
    BTN_UP     = 4'd4,
    BTN_DN     = 4'd5,
    BTN_LT     = 4'd6,
    BTN_RT     = 4'd7,
    BTN_A      = 4'd8,
    BTN_X      = 4'd9,
    BTN_L      = 4'd10,
    BTN_R      = 4'd11
  } joy_btn_t;

  localparam int SCAN_BITS = 17;

  // Auto-fire: X also drives A and Y also drives B while the phase bit is set.
  function automatic logic [11:0] turbo_mix(input logic [11:0] btn, input logic phase);
    turbo_mix        = btn;
    turbo_mix[BTN_A] = btn[BTN_A] | (btn[BTN_X] & phase);
    turbo_mix[BTN_B] = btn[BTN_B] | (btn[BTN_Y] & phase);
  endfunction

endpackage

// File: rtl/joy_port_shift.sv
// One pad port: 17-bit LSB-first capture of inverted serial data.
// Bits 11:0 are the buttons (1 = pressed); bit 16 is the presence sample.
module joy_port_shift
  import joy_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_sample,
  input  logic        i_joy_data,
  output logic [11:0] o_buttons,
  output logic        o_present
);

  logic [SCAN_BITS-1:0] r_shift;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
    end else if (i_sample) begin
      r_shift <= {~i_joy_data, r_shift[SCAN_BITS-1:1]};
    end
  end

  assign o_buttons = r_shift[11:0];
  // A pad pulls its 17th bit low, so the inverted capture reads 1 when present.
  assign o_present = r_shift[SCAN_BITS-1];

endmodule

// File: rtl/joy_scan_scheduler.sv
// Dual-pad serial scan scheduler: frame-sync or interval triggered, results published atomically.
// Optional macro JOY_TURBO_EN adds an auto-fire phase that toggles on every publish.
//
// state       | meaning
// ST_IDLE     | waiting for scan_req, pending request or interval expiry
// ST_LATCH    | joy_strb high for 2*T6 cycles
// ST_CLK_HIGH | joy_clk high for T6 cycles, samples on exit
// ST_CLK_LOW  | joy_clk low for T6 cycles, bit counter advances on exit
// ST_PUBLISH  | one cycle, copies shift data to the outputs
module joy_scan_scheduler
  import joy_pkg::*;
#(
  parameter int FREQ      = 21_500_000,
  parameter int PERIOD_MS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_req,
  output logic        joy_strb,
  output logic        joy_clk,
  input  logic [1:0]  joy_data,
  output logic [11:0] buttons0,
  output logic [11:0] buttons1,
  output logic [1:0]  present,
  output logic        busy,
  output logic        scan_done
);

  localparam int T6       = FREQ / 1_000_000 * 6;
  localparam int INTERVAL = FREQ / 1000 * PERIOD_MS;
  localparam int TMR_W    = $clog2(2 * T6);
  localparam int INT_W    = $clog2(INTERVAL);

  localparam logic [TMR_W-1:0] TMR_LATCH = TMR_W'(2 * T6 - 1);
  localparam logic [TMR_W-1:0] TMR_BIT   = TMR_W'(T6 - 1);
  localparam logic [INT_W-1:0] INT_LAST  = INT_W'(INTERVAL - 1);
  localparam logic [4:0]       BIT_LAST  = 5'(SCAN_BITS - 1);

  joy_state_t       r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [INT_W-1:0] r_int_cnt;
  logic [4:0]       r_bit_cnt;
  logic             r_pending;
  logic             r_scan_done;
  logic [11:0]      r_buttons0, r_buttons1;
  logic [1:0]       r_present;

  logic             w_tc, w_start, w_sample, w_latch_entry, w_publish;
  logic [11:0]      w_btn0, w_btn1, w_pub0, w_pub1;
  logic [1:0]       w_pres;

  assign w_tc          = (r_tmr == '0);
  assign w_start       = scan_req | r_pending | (r_int_cnt == INT_LAST);
  assign w_latch_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_LATCH);
  assign w_publish     = (r_state == ST_PUBLISH);

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    unique case (r_state)
      ST_IDLE:     if (w_start) w_state_nxt = ST_LATCH;
      ST_LATCH:    if (w_tc) w_state_nxt = ST_CLK_HIGH;
      ST_CLK_HIGH: begin
        if (w_tc) begin
          w_state_nxt = ST_CLK_LOW;
          w_sample    = 1'b1;
        end
      end
      ST_CLK_LOW:  if (w_tc) w_state_nxt = (r_bit_cnt == BIT_LAST) ? ST_PUBLISH : ST_CLK_HIGH;
      ST_PUBLISH:  w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_tmr <= (w_state_nxt == ST_LATCH) ? TMR_LATCH : TMR_BIT;
      end else if (!w_tc) begin
        r_tmr <= r_tmr - 1'b1;
      end
      if (w_latch_entry) begin
        r_bit_cnt <= '0;
      end else if ((r_state == ST_CLK_LOW) && w_tc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Interval holds at its terminal value so a long scan cannot wrap past expiry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_int_cnt <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_latch_entry) begin
        r_int_cnt <= '0;
      end else if (r_int_cnt != INT_LAST) begin
        r_int_cnt <= r_int_cnt + 1'b1;
      end
      if (busy && scan_req) begin
        r_pending <= 1'b1;
      end else if (w_latch_entry) begin
        r_pending <= 1'b0;
      end
    end
  end

  joy_port_shift u_port0 (
    .clk       (clk),
    .resetn    (resetn),
    .i_sample  (w_sample),
    .i_joy_data(joy_data[0]),
    .o_buttons (w_btn0),
    .o_present (w_pres[0])
  );

  joy_port_shift u_port1 (
    .clk       (clk),
    .resetn    (resetn),
    .i_sample  (w_sample),
    .i_joy_data(joy_data[1]),
    .o_buttons (w_btn1),
    .o_present (w_pres[1])
  );

`ifdef JOY_TURBO_EN
  logic r_phase;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase <= 1'b0;
    end else if (w_publish) begin
      r_phase <= ~r_phase;
    end
  end

  // The publish that flips the phase already uses the new value.
  assign w_pub0 = turbo_mix(w_btn0, ~r_phase);
  assign w_pub1 = turbo_mix(w_btn1, ~r_phase);
`else
  assign w_pub0 = w_btn0;
  assign w_pub1 = w_btn1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buttons0  <= '0;
      r_buttons1  <= '0;
      r_present   <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_publish;
      if (w_publish) begin
        r_buttons0 <= w_pres[0] ? w_pub0 : 12'h000;
        r_buttons1 <= w_pres[1] ? w_pub1 : 12'h000;
        r_present  <= w_pres;
      end
    end
  end

  assign joy_strb  = (r_state == ST_LATCH);
  assign joy_clk   = (r_state != ST_CLK_LOW);
  assign busy      = (r_state != ST_IDLE);
  assign scan_done = r_scan_done;
  assign buttons0  = r_buttons0;
  assign buttons1  = r_buttons1;
  assign present   = r_present;

endmodule

// File: tb/tb_joy_scan_scheduler.sv
// Directed bench for joy_scan_scheduler at FREQ=1 MHz, PERIOD_MS=1 (T6=6, interval 1000 cycles).
// Two behavioural pads shift 17-bit words; expected values are hand-derived constants.
module tb_joy_scan_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        scan_req;
  logic        joy_strb, joy_clk;
  logic [1:0]  joy_data;
  logic [11:0] buttons0, buttons1;
  logic [1:0]  present;
  logic        busy, scan_done;

  joy_scan_scheduler #(.FREQ(1_000_000), .PERIOD_MS(1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .scan_req (scan_req),
    .joy_strb (joy_strb),
    .joy_clk  (joy_clk),
    .joy_data (joy_data),
    .buttons0 (buttons0),
    .buttons1 (buttons1),
    .present  (present),
    .busy     (busy),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pad model: word bit k is "pressed" for serial bit k; bit 16 set means pad answers present.
  logic [16:0] pad0, pad1;
  logic [4:0]  pad_idx = 5'd0;

  always @(posedge joy_clk or posedge joy_strb) begin
    if (joy_strb) pad_idx <= 5'd0;
    else if (pad_idx < 5'd17) pad_idx <= pad_idx + 5'd1;
  end

  assign joy_data[0] = (pad_idx < 5'd17) ? ~pad0[pad_idx] : 1'b1;
  assign joy_data[1] = (pad_idx < 5'd17) ? ~pad1[pad_idx] : 1'b1;

  int   cyc = 0;
  int   strb_cycles = 0, clk_pulses = 0, bad_width = 0, run = 0;
  int   fall_cnt = 0, rise_cnt = 0, last_rise = 0, done_cnt = 0;
  logic prev_strb = 1'b0, prev_clk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (joy_strb) strb_cycles <= strb_cycles + 1;
    if (joy_strb && !prev_strb) begin
      rise_cnt  <= rise_cnt + 1;
      last_rise <= cyc;
    end
    if (!joy_clk) begin
      if (prev_clk) fall_cnt <= fall_cnt + 1;
      run <= run + 1;
    end else if (run > 0) begin
      clk_pulses <= clk_pulses + 1;
      if (run != 6) bad_width <= bad_width + 1;
      run <= 0;
    end
    if (scan_done) done_cnt <= done_cnt + 1;
    prev_strb <= joy_strb;
    prev_clk  <= joy_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_req();
    scan_req = 1'b1;
    step(1);
    scan_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!scan_done && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(scan_done), 32'd1);
  endtask

  task automatic wait_rise(input int prev, input int budget, input string tag);
    int n = 0;
    while (rise_cnt == prev && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, rise_cnt - prev, 32'd1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(2);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, r1, c0, rb, f0, n;
    logic exp_a;
    resetn   = 1'b0;
    scan_req = 1'b0;
    pad0     = '0;
    pad1     = '0;
    step(3);
    chk("rst_strb",  32'(joy_strb),  32'd0);
    chk("rst_clk",   32'(joy_clk),   32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(scan_done), 32'd0);
    chk("rst_btn0",  32'(buttons0),  32'h000);
    chk("rst_btn1",  32'(buttons1),  32'h000);
    chk("rst_pres",  32'(present),   32'd0);
    resetn = 1'b1;
    step(3);

    // A pressed on port 0, nothing on port 1
    pad0 = 17'h10100;
    pad1 = 17'h00000;
    strb_cycles = 0; clk_pulses = 0; bad_width = 0; done_cnt = 0;
    chk("s1_busy_pre", 32'(busy), 32'd0);
    pulse_req();
    chk("s1_busy", 32'(busy), 32'd1);
    wait_done(400, "s1_done");
    step(3);
    chk("s1_strb_len", strb_cycles, 32'd12);
    chk("s1_clk_pulses", clk_pulses, 32'd17);
    chk("s1_clk_width_bad", bad_width, 32'd0);
    chk("s1_btn0", 32'(buttons0), 32'h100);
    chk("s1_btn1", 32'(buttons1), 32'h000);
    chk("s1_pres", 32'(present), 32'd1);
    chk("s1_done_cnt", done_cnt, 32'd1);
    chk("s1_idle", 32'(busy), 32'd0);

    // Both pads, mixed buttons
    pad0 = 17'h10009;
    pad1 = 17'h10802;
    pulse_req();
    wait_done(400, "s2_done");
    chk("s2_btn0", 32'(buttons0), 32'h009);
    chk("s2_btn1", 32'(buttons1), 32'h802);
    chk("s2_pres", 32'(present), 32'd3);

    // Port 0 drives buttons but no presence bit: must be masked
    pad0 = 17'h00FFF;
    pad1 = 17'h1FFFF;
    pulse_req();
    wait_done(400, "s3_done");
    chk("s3_btn0_masked", 32'(buttons0), 32'h000);
    chk("s3_btn1", 32'(buttons1), 32'hFFF);
    chk("s3_pres", 32'(present), 32'd2);

    // Three requests during a scan collapse into one deferred scan
    do_reset();
    pad0 = 17'h10001;
    pad1 = 17'h00000;
    r0 = rise_cnt;
    done_cnt = 0;
    pulse_req();
    step(20);  pulse_req();
    step(30);  pulse_req();
    step(40);  pulse_req();
    wait_done(400, "pend_first_done");
    step(1);
    chk("pend_restart", 32'(joy_strb), 32'd1);
    wait_done(400, "pend_second_done");
    step(60);
    chk("pend_scans", rise_cnt - r0, 32'd2);
    chk("pend_done_cnt", done_cnt, 32'd2);
    chk("pend_btn0", 32'(buttons0), 32'h001);

    // Autonomous rescans every 1000 cycles from LATCH entry
    r1 = last_rise;
    wait_rise(rise_cnt, 1200, "auto1_start");
    chk("auto_gap1", last_rise - r1, 32'd1000);

    // scan_req in the exact expiry cycle starts a single scan
    c0 = last_rise;
    n = 0;
    while (cyc != c0 + 999 && n < 1200) begin
      step(1);
      n++;
    end
    rb = rise_cnt;
    scan_req = 1'b1;
    step(1);
    scan_req = 1'b0;
    wait_rise(rb, 50, "coinc_start");
    chk("coinc_gap", last_rise - c0, 32'd1000);
    wait_done(400, "coinc_done");
    step(100);
    chk("coinc_single", rise_cnt - rb, 32'd1);
    c0 = last_rise;
    wait_rise(rise_cnt, 1200, "auto2_start");
    chk("auto_gap2", last_rise - c0, 32'd1000);

    // Reset during CLK_LOW of bit 8 abandons the scan
    do_reset();
    pad0 = 17'h1FFFF;
    pad1 = 17'h1FFFF;
    done_cnt = 0;
    f0 = fall_cnt;
    pulse_req();
    n = 0;
    while (fall_cnt < f0 + 9 && n < 300) begin
      step(1);
      n++;
    end
    chk("mid_in_low", 32'(joy_clk), 32'd0);
    resetn = 1'b0;
    #1;
    chk("mid_rst_clk", 32'(joy_clk), 32'd1);
    chk("mid_rst_strb", 32'(joy_strb), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(scan_done), 32'd0);
    step(2);
    resetn = 1'b1;
    step(300);
    chk("mid_no_done", done_cnt, 32'd0);
    chk("mid_btn0", 32'(buttons0), 32'h000);
    chk("mid_btn1", 32'(buttons1), 32'h000);
    chk("mid_pres", 32'(present), 32'd0);
    pulse_req();
    wait_done(400, "post_rst_done");
    chk("post_rst_btn0", 32'(buttons0), 32'hFFF);
    chk("post_rst_pres", 32'(present), 32'd3);

    // X held: A follows the turbo phase when enabled, otherwise stays released
    do_reset();
    pad0 = 17'h10200;
    pad1 = 17'h00000;
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      wait_done(400, "turbo_done");
`ifdef JOY_TURBO_EN
      exp_a = (k % 2 == 0);
`else
      exp_a = 1'b0;
`endif
      chk("turbo_a", 32'(buttons0[8]), 32'(exp_a));
      chk("turbo_x", 32'(buttons0[9]), 32'd1);
      step(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
